// File: rtl/spi_ctl_pkg.sv
// Shared types and constants for the SPI master controller.
package spi_ctl_pkg;

  localparam int WORD_W          = 32;
  localparam int NUM_CS          = 4;
  localparam int CLK_DIV_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: pulses tick once every CLK_DIV enabled cycles.
// The counter is held at zero while disabled, so every transfer starts on a
// clean phase.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic en,
  output logic tick
);

  localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..CLK_DIV-1 while enabled, wrapping at the last value.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/spi_master_ctl.sv
// SPI master controller, mode 0, MSB first, one 32-bit word per transfer.
// A rising edge on SPI_START_I in IDLE launches SETUP -> SHIFT -> HOLD; data
// and target select are captured at launch so later input changes are inert.
module spi_master_ctl
  import spi_ctl_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [WORD_W-1:0] SPI_DATA_I,
  input  logic              SPI_START_I,
  input  logic [1:0]        SPI_SEL_I,
  output logic [WORD_W-1:0] SPI_DATA_O,
  output logic              SPI_DONE_O,
  output logic              SPI_BUSY_O,
  output logic              SCLK_O,
  output logic              MOSI_O,
  input  logic              MISO_I,
  output logic [NUM_CS-1:0] CS_N_O
);

  spi_state_e        state;
  spi_state_e        state_next;
  logic              start_d;
  logic              start_edge;
  logic              accept;
  logic              tick;
  logic              sclk_q;
  logic              last_bit;
  logic [4:0]        bit_cnt;
  logic [1:0]        sel_q;
  logic [WORD_W-1:0] tx_shift;
  logic [WORD_W-1:0] rx_shift;

  assign start_edge = SPI_START_I && !start_d;
  assign last_bit   = (bit_cnt == 5'd31);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en        (state != ST_IDLE),
    .tick      (tick)
  );

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus busy and chip-select outputs.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    SPI_BUSY_O = 1'b1;
    CS_N_O     = '1;
    case (state)
      ST_IDLE: begin
        SPI_BUSY_O = 1'b0;
        if (start_edge) begin
          accept     = 1'b1;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick && sclk_q && last_bit) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (tick) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (state != ST_IDLE) CS_N_O[sel_q] = 1'b0;
  end

  // Start-edge history, tracked every cycle regardless of state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      start_d <= 1'b0;
    end else begin
      start_d <= SPI_START_I;
    end
  end

  // Launch capture, SCLK phase, shift registers and bit counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_shift <= '0;
      rx_shift <= '0;
      sel_q    <= '0;
      sclk_q   <= 1'b0;
      bit_cnt  <= '0;
    end else if (accept) begin
      tx_shift <= SPI_DATA_I;
      sel_q    <= SPI_SEL_I;
      sclk_q   <= 1'b0;
      bit_cnt  <= '0;
    end else if (state == ST_SHIFT && tick) begin
      if (!sclk_q) begin
        sclk_q   <= 1'b1;
        rx_shift <= {rx_shift[WORD_W-2:0], MISO_I};
      end else begin
        sclk_q <= 1'b0;
        if (!last_bit) begin
          bit_cnt  <= bit_cnt + 5'd1;
          tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
        end
      end
    end
  end

  // Result word and done flag: cleared on launch, loaded when HOLD ends.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      SPI_DATA_O <= '0;
      SPI_DONE_O <= 1'b0;
    end else if (accept) begin
      SPI_DONE_O <= 1'b0;
    end else if (state == ST_HOLD && tick) begin
      SPI_DATA_O <= rx_shift;
      SPI_DONE_O <= 1'b1;
    end
  end

  assign SCLK_O = sclk_q;
  assign MOSI_O = (state != ST_IDLE) ? tx_shift[WORD_W-1] : 1'b0;

endmodule

// File: tb/tb_spi_master_ctl.sv
// Directed bench for spi_master_ctl: one instance at CLK_DIV=2 and one at
// CLK_DIV=1 share stimulus; use_fast picks whose outputs are observed.
module tb_spi_master_ctl;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] data;
  logic [1:0]  sel;
  logic        loop_en;
  logic        miso_val;
  logic        use_fast;

  logic [31:0] data_o2, data_o1;
  logic        done2, done1, busy2, busy1;
  logic        sclk2, sclk1, mosi2, mosi1;
  logic        miso2, miso1;
  logic [3:0]  cs2, cs1;

  logic [31:0] obs_data;
  logic        obs_done, obs_busy, obs_sclk, obs_mosi;
  logic [3:0]  obs_cs;

  int tests_run    = 0;
  int tests_failed = 0;

  assign miso2 = loop_en ? mosi2 : miso_val;
  assign miso1 = loop_en ? mosi1 : miso_val;

  assign obs_data = use_fast ? data_o1 : data_o2;
  assign obs_done = use_fast ? done1   : done2;
  assign obs_busy = use_fast ? busy1   : busy2;
  assign obs_sclk = use_fast ? sclk1   : sclk2;
  assign obs_mosi = use_fast ? mosi1   : mosi2;
  assign obs_cs   = use_fast ? cs1     : cs2;

  spi_master_ctl #(.CLK_DIV(2)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .SPI_DATA_I  (data),
    .SPI_START_I (start),
    .SPI_SEL_I   (sel),
    .SPI_DATA_O  (data_o2),
    .SPI_DONE_O  (done2),
    .SPI_BUSY_O  (busy2),
    .SCLK_O      (sclk2),
    .MOSI_O      (mosi2),
    .MISO_I      (miso2),
    .CS_N_O      (cs2)
  );

  spi_master_ctl #(.CLK_DIV(1)) dut_fast (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .SPI_DATA_I  (data),
    .SPI_START_I (start),
    .SPI_SEL_I   (sel),
    .SPI_DATA_O  (data_o1),
    .SPI_DONE_O  (done1),
    .SPI_BUSY_O  (busy1),
    .SCLK_O      (sclk1),
    .MOSI_O      (mosi1),
    .MISO_I      (miso1),
    .CS_N_O      (cs1)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [1:0] s,
                               input logic lp, input logic mv);
    @(negedge clk);
    data     = d;
    sel      = s;
    loop_en  = lp;
    miso_val = mv;
    start    = 1'b1;
  endtask

  task automatic releaseStart();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((busy1 || busy2) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", {30'd0, busy1, busy2}, 32'd0);
  endtask

  // Counts posedges from the launch edge until DONE, recording SCLK rises,
  // MOSI at each rise, chip-select while busy and the first SCLK period.
  task automatic waitDone(input logic [3:0] exp_cs, input bit disturb,
                          output int edges, output int rises,
                          output logic [31:0] mosi_seq, output bit cs_ok,
                          output int period);
    logic prev_sclk;
    int   rise1;
    edges     = 0;
    rises     = 0;
    mosi_seq  = '0;
    cs_ok     = 1'b1;
    period    = 0;
    rise1     = 0;
    prev_sclk = obs_sclk;
    while (edges < 2000) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (obs_busy && obs_cs !== exp_cs) cs_ok = 1'b0;
      if (obs_sclk && !prev_sclk) begin
        rises++;
        mosi_seq = {mosi_seq[30:0], obs_mosi};
        if (rises == 1) rise1 = edges;
        if (rises == 2) period = edges - rise1;
      end
      prev_sclk = obs_sclk;
      if (disturb) begin
        if (edges == 40) begin
          sel   = 2'd3;
          data  = 32'h0;
          start = 1'b0;
        end
        if (edges == 44) start = 1'b1;
        if (edges == 48) start = 1'b0;
      end
      if (obs_done) break;
    end
  endtask

  initial begin
    int          edges, rises, period;
    logic [31:0] mosi_seq;
    bit          cs_ok, held_ok, quiet_ok;

    reset_n  = 1'b0;
    start    = 1'b0;
    data     = '0;
    sel      = '0;
    loop_en  = 1'b0;
    miso_val = 1'b0;
    use_fast = 1'b0;

    // Reset state.
    #22;
    checkOutput("rst_sclk", {31'd0, sclk2}, 32'd0);
    checkOutput("rst_mosi", {31'd0, mosi2}, 32'd0);
    checkOutput("rst_cs",   {28'd0, cs2},   32'hF);
    checkOutput("rst_data", data_o2,        32'd0);
    checkOutput("rst_done", {31'd0, done2}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy2}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback, CLK_DIV=2, sel 2.
    applyStimulus(32'hA5A50F0F, 2'd2, 1'b1, 1'b0);
    waitDone(4'b1011, 1'b0, edges, rises, mosi_seq, cs_ok, period);
    checkOutput("loop_latency", edges,    32'd133);
    checkOutput("loop_data",    data_o2,  32'hA5A50F0F);
    checkOutput("loop_mosi",    mosi_seq, 32'hA5A50F0F);
    checkOutput("loop_cs",      {31'd0, cs_ok}, 32'd1);
    checkOutput("loop_rises",   rises,    32'd32);
    checkOutput("loop_period",  period,   32'd4);
    checkOutput("loop_cs_idle", {28'd0, cs2}, 32'hF);
    releaseStart();
    waitIdle();

    // MISO tied high, data 0, sel 0.
    applyStimulus(32'h0, 2'd0, 1'b0, 1'b1);
    waitDone(4'b1110, 1'b0, edges, rises, mosi_seq, cs_ok, period);
    checkOutput("ones_data",  data_o2,  32'hFFFFFFFF);
    checkOutput("ones_cs",    {31'd0, cs_ok}, 32'd1);
    checkOutput("ones_rises", rises,    32'd32);
    checkOutput("ones_mosi",  mosi_seq, 32'h0);
    releaseStart();
    waitIdle();

    // START held high for 500 cycles: exactly one transfer.
    applyStimulus(32'h12345678, 2'd1, 1'b1, 1'b0);
    waitDone(4'b1101, 1'b0, edges, rises, mosi_seq, cs_ok, period);
    checkOutput("held_latency", edges,   32'd133);
    checkOutput("held_data",    data_o2, 32'h12345678);
    held_ok = 1'b1;
    for (int i = edges; i < 500; i++) begin
      @(negedge clk);
      if (busy2 || !done2) held_ok = 1'b0;
    end
    checkOutput("held_single", {31'd0, held_ok}, 32'd1);
    releaseStart();
    applyStimulus(32'h87654321, 2'd1, 1'b1, 1'b0);
    waitDone(4'b1101, 1'b0, edges, rises, mosi_seq, cs_ok, period);
    checkOutput("held_relaunch", edges,   32'd133);
    checkOutput("held_data2",    data_o2, 32'h87654321);
    releaseStart();
    waitIdle();

    // START pulse and SEL/DATA change during SHIFT are ignored.
    applyStimulus(32'h0F0F1234, 2'd0, 1'b1, 1'b0);
    waitDone(4'b1110, 1'b1, edges, rises, mosi_seq, cs_ok, period);
    checkOutput("dist_cs",      {31'd0, cs_ok}, 32'd1);
    checkOutput("dist_data",    data_o2, 32'h0F0F1234);
    checkOutput("dist_latency", edges,   32'd133);
    quiet_ok = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (busy2 || !done2) quiet_ok = 1'b0;
    end
    checkOutput("dist_no_second", {31'd0, quiet_ok}, 32'd1);
    waitIdle();

    // Asynchronous reset near bit 10 of SHIFT, then relaunch from reset.
    applyStimulus(32'hDEADBEEF, 2'd3, 1'b1, 1'b0);
    repeat (43) @(posedge clk);
    @(negedge clk);
    checkOutput("abort_busy_before", {31'd0, busy2}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort_cs",   {28'd0, cs2},   32'hF);
    checkOutput("abort_sclk", {31'd0, sclk2}, 32'd0);
    checkOutput("abort_data", data_o2,        32'd0);
    checkOutput("abort_busy", {31'd0, busy2}, 32'd0);
    checkOutput("abort_done", {31'd0, done2}, 32'd0);
    data = 32'hCAFEF00D;
    @(negedge clk);
    reset_n = 1'b1;
    waitDone(4'b0111, 1'b0, edges, rises, mosi_seq, cs_ok, period);
    checkOutput("post_rst_latency", edges,   32'd133);
    checkOutput("post_rst_data",    data_o2, 32'hCAFEF00D);
    checkOutput("post_rst_cs",      {31'd0, cs_ok}, 32'd1);
    releaseStart();
    waitIdle();

    // CLK_DIV=1 instance: 2-cycle SCLK, DONE at N+67.
    use_fast = 1'b1;
    applyStimulus(32'h80000001, 2'd1, 1'b1, 1'b0);
    waitDone(4'b1101, 1'b0, edges, rises, mosi_seq, cs_ok, period);
    checkOutput("fast_latency", edges,   32'd67);
    checkOutput("fast_period",  period,  32'd2);
    checkOutput("fast_data",    data_o1, 32'h80000001);
    checkOutput("fast_rises",   rises,   32'd32);
    checkOutput("fast_mosi",    mosi_seq, 32'h80000001);
    releaseStart();
    waitIdle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_master_ctl.md
SPI_MASTER_CTL -- requirements
Module: spi_master_ctl

Interface
REQ-001 Parameter CLK_DIV, default 4, SHALL set the SCLK half-period in clk_i cycles (legal 1..255).
REQ-002 Port clk_i  input  1  sole clock; all logic on the rising edge.
REQ-003 Port reset_n_i  input  1  asynchronous, active-low reset.
REQ-004 Port SPI_DATA_I  input  32  word to transmit, from the register-file SPI data-out register.
REQ-005 Port SPI_START_I  input  1  software start level; only its rising edge launches a transfer.
REQ-006 Port SPI_SEL_I  input  2  target device index 0..3.
REQ-007 Port SPI_DATA_O  output  32  last received word.
REQ-008 Port SPI_DONE_O  output  1  transfer-complete flag.
REQ-009 Port SPI_BUSY_O  output  1  high while a transfer is in progress.
REQ-010 Ports SCLK_O (output, 1), MOSI_O (output, 1), MISO_I (input, 1), CS_N_O (output, 4) SHALL form the SPI pin interface, mode 0, MSB first.

Function
REQ-011 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD; SPI_BUSY_O SHALL be high in every state except IDLE.
REQ-012 A start edge SHALL be detected as SPI_START_I=1 with registered start_d=0; start_d SHALL track SPI_START_I every cycle in every state.
REQ-013 On a start edge in IDLE at cycle N, the block SHALL latch SPI_DATA_I and SPI_SEL_I, clear SPI_DONE_O, and enter SETUP at N+1.
REQ-014 A start edge outside IDLE SHALL be ignored and SHALL NOT be queued; a START_I held high SHALL launch exactly one transfer.
REQ-015 In SETUP (cycles N+1..N+CLK_DIV), CS_N_O SHALL drive bit sel low and other bits high, SCLK_O SHALL be 0, and MOSI_O SHALL be latched bit 31.
REQ-016 SHIFT SHALL last 64*CLK_DIV cycles (N+CLK_DIV+1..N+65*CLK_DIV) and generate 32 SCLK periods, low half first, then high half.
REQ-017 MISO_I SHALL be sampled into the receive shift register on each SCLK rising edge; MOSI_O SHALL advance to the next lower bit on each SCLK falling edge except the last.
REQ-018 In HOLD (CLK_DIV cycles), SCLK_O SHALL be 0 and CS remains asserted; on exit, SPI_DATA_O SHALL load the received word, SPI_DONE_O SHALL go high, CS_N_O SHALL be 4'b1111, and the FSM SHALL return to IDLE.
REQ-019 SPI_DONE_O SHALL first be high at cycle N+66*CLK_DIV+1 and SHALL stay high until the next accepted start.
REQ-020 Changes to SPI_DATA_I or SPI_SEL_I after launch SHALL have no effect on the current transfer.
REQ-021 The divider counter SHALL be wide enough for CLK_DIV-1, SHALL wrap to 0 at CLK_DIV-1, and the bit counter SHALL count 0..31 without overflow.

Reset
REQ-022 While reset_n_i=0, regardless of state, outputs SHALL be: SCLK_O=0, MOSI_O=0, CS_N_O=4'b1111, SPI_DATA_O=0, SPI_DONE_O=0, SPI_BUSY_O=0, with the FSM in IDLE and start_d=0.
REQ-023 A reset asserted mid-transfer SHALL abort the transfer with no partial update of SPI_DATA_O.
REQ-024 If SPI_START_I is already high when reset releases, one transfer SHALL launch on the first post-reset clock.

Structure
REQ-025 Package spi_ctl_pkg SHALL hold the state enumeration, WORD_W=32, NUM_CS=4, and the CLK_DIV default.
REQ-026 The half-period tick generator SHALL be the single sub-module spi_clk_div (counter plus tick output, enabled outside IDLE).

Verification
REQ-027 With CLK_DIV=2, DATA_I=0xA5A50F0F, SEL=2, and MISO looped to MOSI: CS_N_O=4'b1011 during the transfer; MOSI sequence matches 0xA5A50F0F MSB first; SPI_DATA_O=0xA5A50F0F; DONE at N+133.
REQ-028 With MISO tied to 1, DATA_I=0 and SEL=0: SPI_DATA_O=0xFFFFFFFF, CS_N_O=4'b1110, 32 SCLK rising edges counted.
REQ-029 START_I held high for 500 cycles with CLK_DIV=2: exactly one transfer; DONE stays 1 until START_I falls and rises again.
REQ-030 START_I pulsed and SEL changed 0->3 during SHIFT: no second transfer; CS_N_O stays 4'b1110 throughout.
REQ-031 reset_n_i pulsed low at bit 10 of SHIFT: CS_N_O=4'b1111, SCLK_O=0 and SPI_DATA_O=0 immediately (asynchronously), BUSY=0; the next start edge yields a full, correct transfer.
REQ-032 With CLK_DIV=1 and DATA_I=0x80000001: SCLK period is 2 cycles, DONE at N+67, and loopback returns 0x80000001.
